demux_4_64bit_reg: RTL and testbench



---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_out_slot_64.sv | 57 +++++
 rtl/demux_4_64bit_reg.sv | 88 ++++++++
 tb/tb_demux_4_64bit_reg.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-4 result distributor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  localparam int DEMUX_WIDTH   = 64;
  localparam int DEMUX_NUM_OUT = 4;
  localparam int DEMUX_SEL_W   = 2;
  localparam int DEMUX_CNT_W   = 32;

  typedef logic [DEMUX_WIDTH-1:0] demux_data_t;
  typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;
  typedef logic [DEMUX_CNT_W-1:0] demux_cnt_t;

  // A slot either holds a word for its consumer or it does not.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot_64.sv
// One-entry valid/ready holding register for a single 64-bit destination.
// Latency: a word loaded in cycle N is presented in cycle N+1.
// Backpressure: holds the word stable until rdy_i; the parent only loads when empty or draining.
module demux_out_slot_64
  import demux_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  demux_data_t load_dat_i,
  input  logic        rdy_i,
  output logic        vld_o,
  output demux_data_t dat_o
);

  slot_state_e state_q, state_d;
  demux_data_t data_q, data_d;

  // State and data registers; reset wins over any same-cycle handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always fills (refill on drain included); a drain alone empties.
  // Data is kept on drain so the last word stays visible.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = load_dat_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = load_dat_i;
        end else if (rdy_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign vld_o = (state_q == SLOT_FULL);
  assign dat_o = data_q;

endmodule

// File: rtl/demux_4_64bit_reg.sv
// Registered 1-to-4 distributor steering a 64-bit word to the slot named by in_select.
// Latency: one cycle from input accept to out_valid[sel].
// Backpressure: in_ready drops only when the selected slot is full and not draining.
// Optional build macro DEMUX_XFER_COUNT_EN adds per-slot 32-bit transfer counters on xfer_count.
module demux_4_64bit_reg
  import demux_pkg::*;
#(
  parameter int WIDTH   = DEMUX_WIDTH,
  parameter int NUM_OUT = DEMUX_NUM_OUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_select,
  input  logic [WIDTH-1:0]   in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data0,
  output logic [WIDTH-1:0]   out_data1,
  output logic [WIDTH-1:0]   out_data2,
  output logic [WIDTH-1:0]   out_data3
`ifdef DEMUX_XFER_COUNT_EN
  ,
  output logic [NUM_OUT*DEMUX_CNT_W-1:0] xfer_count
`endif
);

  demux_sel_t          sel;
  logic                accept;
  logic [NUM_OUT-1:0]  load;
  demux_data_t         slot_dat [NUM_OUT];

  assign sel = in_select;

  // Ready depends only on slot state and the consumer's ready, never on in_valid.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  // Decode the select into a one-hot load enable for the accepted word.
  always_comb begin
    load = '0;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_out_slot_64 u_slot (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (load[k]),
      .load_dat_i (in_data),
      .rdy_i      (out_ready[k]),
      .vld_o      (out_valid[k]),
      .dat_o      (slot_dat[k])
    );
  end

  assign out_data0 = slot_dat[0];
  assign out_data1 = slot_dat[1];
  assign out_data2 = slot_dat[2];
  assign out_data3 = slot_dat[3];

`ifdef DEMUX_XFER_COUNT_EN
  demux_cnt_t cnt_q [NUM_OUT];

  // Count completed drains per slot; natural 32-bit wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_valid[k] && out_ready[k]) cnt_q[k] <= cnt_q[k] + demux_cnt_t'(1);
      end
    end
  end

  // Flatten counters; counter k sits at bits [32k+31:32k].
  always_comb begin
    xfer_count = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      xfer_count[k*DEMUX_CNT_W +: DEMUX_CNT_W] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_demux_4_64bit_reg.sv
// Self-checking bench for demux_4_64bit_reg: directed scenarios plus random traffic
// against a per-slot occupancy model. Counter checks only exist when DEMUX_XFER_COUNT_EN is defined.
module tb_demux_4_64bit_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_select = 2'd0;
  logic [63:0] in_data = 64'h0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'b0000;
  logic [63:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_XFER_COUNT_EN
  logic [127:0] xfer_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which slots hold a word, what each slot shows, transfer totals.
  logic [3:0]  mvld = 4'b0000;
  logic [63:0] mdat [4];
  logic [31:0] mcnt [4];

  always #5 clock = ~clock;

  demux_4_64bit_reg dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_select (in_select),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  function automatic logic [63:0] dut_dat(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // A word can go in unless its destination is occupied and its consumer is not taking it.
  function automatic logic model_ready(input logic [1:0] s, input logic [3:0] r);
    return !mvld[s] || r[s];
  endfunction

  // Drive inputs, then let combinational ready settle.
  task automatic set_in(input logic rst, input logic v, input logic [1:0] s,
                        input logic [63:0] d, input logic [3:0] r);
    reset = rst; in_valid = v; in_select = s; in_data = d; out_ready = r;
    #1;
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic tick();
    logic acc;
    acc = in_valid && model_ready(in_select, out_ready);
    @(posedge clock);
    if (reset) begin
      mvld = 4'b0000;
      for (int k = 0; k < 4; k++) begin mdat[k] = 64'h0; mcnt[k] = 32'h0; end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mvld[k] && out_ready[k]) begin
          mcnt[k] = mcnt[k] + 32'd1;
          mvld[k] = 1'b0;
        end
        if (acc && in_select == k[1:0]) begin
          mvld[k] = 1'b1;
          mdat[k] = in_data;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 2'd0, 64'h0, 4'b0000);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0000);
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 2'd1, 64'h1234, 4'b1111);
    tick();
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 4'b0000);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dut_dat(k) !== 64'h0) begin
        miscompares++; $display("FAIL reset_out_data%0d got=%h exp=0", k, dut_dat(k));
      end
    end
    for (int s = 0; s < 4; s++) begin
      set_in(1'b0, 1'b0, s[1:0], 64'h0, 4'b0000);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
  endtask

  task automatic test_single_word();
    set_in(1'b0, 1'b1, 2'd2, 64'hDEADBEEF_00000001, 4'b0000);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0100) begin
      miscompares++; $display("FAIL single_out_valid got=%b exp=%b", out_valid, 4'b0100);
    end
    vectors++;
    if (out_data2 !== 64'hDEADBEEF_00000001) begin
      miscompares++; $display("FAIL single_out_data2 got=%h exp=deadbeef00000001", out_data2);
    end
    vectors++;
    if ({out_data0, out_data1, out_data3} !== 192'h0) begin
      miscompares++; $display("FAIL single_others got=%h_%h_%h exp=0", out_data0, out_data1, out_data3);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1'b0, 1'b1, 2'd1, 64'h11, 4'b0000);
    tick();
    set_in(1'b0, 1'b1, 2'd1, 64'h22, 4'b0000);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_blocked_ready got=%b exp=0", in_ready);
    end
    tick();
    vectors++;
    if (out_data1 !== 64'h11) begin
      miscompares++; $display("FAIL bp_slot1_held got=%h exp=11", out_data1);
    end
    set_in(1'b0, 1'b1, 2'd3, 64'h3, 4'b0000);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_other_ready got=%b exp=1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b1010) begin
      miscompares++; $display("FAIL bp_out_valid got=%b exp=%b", out_valid, 4'b1010);
    end
    vectors++;
    if (out_data3 !== 64'h3) begin
      miscompares++; $display("FAIL bp_out_data3 got=%h exp=3", out_data3);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b0, 1'b1, 2'd0, 64'(i), 4'b1111);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid[0] !== 1'b1 || out_data0 !== 64'(i)) begin
        miscompares++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, out_valid[0], out_data0, 64'(i));
      end
    end
  endtask

  task automatic test_drain_refill();
    do_reset();
    set_in(1'b0, 1'b1, 2'd0, 64'hA, 4'b0000);
    tick();
    set_in(1'b0, 1'b1, 2'd0, 64'hB, 4'b0001);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL refill_ready got=%b exp=1", in_ready);
    end
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0000);
    vectors++;
    if (out_valid[0] !== 1'b1 || out_data0 !== 64'hB) begin
      miscompares++; $display("FAIL refill_slot0 got=%b/%h exp=1/b", out_valid[0], out_data0);
    end
    // Drain alone empties but keeps the last word visible.
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0001);
    tick();
    vectors++;
    if (out_valid[0] !== 1'b0 || out_data0 !== 64'hB) begin
      miscompares++; $display("FAIL drain_keep got=%b/%h exp=0/b", out_valid[0], out_data0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, k[1:0], 64'h100 + 64'(k), 4'b0000);
      tick();
    end
    vectors++;
    if (out_valid !== 4'b1111) begin
      miscompares++; $display("FAIL midrst_full got=%b exp=1111", out_valid);
    end
    set_in(1'b1, 1'b1, 2'd0, 64'hBAD, 4'b1111);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_out_valid got=%b exp=0000", out_valid);
    end
    vectors++;
    if ({out_data0, out_data1, out_data2, out_data3} !== 256'h0) begin
      miscompares++; $display("FAIL midrst_data got=%h_%h_%h_%h exp=0", out_data0, out_data1, out_data2, out_data3);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_no_capture got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_random();
    logic        v, rst;
    logic [1:0]  s;
    logic [3:0]  r;
    logic [63:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 2'($urandom_range(0, 3));
      r   = 4'($urandom);
      d   = {$urandom, $urandom};
      set_in(rst, v, s, d, r);
      vectors++;
      if (in_ready !== model_ready(s, r)) begin
        miscompares++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, model_ready(s, r));
      end
      tick();
      vectors++;
      if (out_valid !== mvld) begin
        miscompares++; $display("FAIL rand_out_valid[%0d] got=%b exp=%b", i, out_valid, mvld);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (dut_dat(k) !== mdat[k]) begin
          miscompares++; $display("FAIL rand_data%0d[%0d] got=%h exp=%h", k, i, dut_dat(k), mdat[k]);
        end
      end
`ifdef DEMUX_XFER_COUNT_EN
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (xfer_count[k*32 +: 32] !== mcnt[k]) begin
          miscompares++; $display("FAIL rand_cnt%0d[%0d] got=%h exp=%h", k, i, xfer_count[k*32 +: 32], mcnt[k]);
        end
      end
`endif
    end
  endtask

`ifdef DEMUX_XFER_COUNT_EN
  task automatic test_counter_wrap();
    do_reset();
    set_in(1'b0, 1'b1, 2'd0, 64'h5, 4'b0000);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b0001);
    tick();
    dut.cnt_q[3] = 32'hFFFFFFFE;
    mcnt[3] = 32'hFFFFFFFE;
    set_in(1'b0, 1'b1, 2'd3, 64'h31, 4'b1000);
    tick();
    set_in(1'b0, 1'b1, 2'd3, 64'h32, 4'b1000);
    tick();
    set_in(1'b0, 1'b1, 2'd3, 64'h33, 4'b1000);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 64'h0, 4'b1000);
    tick();
    vectors++;
    if (xfer_count[127:96] !== 32'h1 || mcnt[3] !== 32'h1) begin
      miscompares++; $display("FAIL cnt_wrap got=%h exp=1", xfer_count[127:96]);
    end
    vectors++;
    if (xfer_count[95:0] !== {32'h0, 32'h0, 32'h1}) begin
      miscompares++; $display("FAIL cnt_others got=%h exp=000000000000000000000001", xfer_count[95:0]);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 4; k++) begin mdat[k] = 64'h0; mcnt[k] = 32'h0; end
    @(negedge clock);
    test_reset();
    test_single_word();
    test_backpressure();
    test_stream();
    test_drain_refill();
    test_mid_reset();
`ifdef DEMUX_XFER_COUNT_EN
    test_counter_wrap();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
